// File: rtl/forward_hazard_unit.sv
// Operand forwarding selector and load-use stall generator for an in-order
// pipeline, with a stall watchdog and saturating activity counters.
module forward_hazard_unit #(
  parameter int NUM_SRC   = 2,
  parameter int NUM_STG   = 2,
  parameter int ADDR_W    = 5,
  parameter int MAX_STALL = 15,
  localparam int SEL_W    = $clog2(NUM_STG + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_STG-1:0]        stg_wr,
  input  logic [NUM_STG*ADDR_W-1:0] stg_addr,
  input  logic [NUM_STG-1:0]        stg_rdy,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic                      stall,
  output logic                      wd_err,
  output logic [15:0]               stall_cnt,
  output logic [15:0]               fwd_cnt
);

  typedef enum logic {RUN, HOLD} stateT;

  stateT      state, nextState;
  logic [7:0] runCnt;
  logic       anyHazard;
  logic       anyFwd;
  logic       enterHold;
  logic       holdTick;
  logic       wdTrip;

  // Per-operand priority search: the first (nearest) matching stage wins,
  // and its readiness alone decides whether the operand hazards.
  always_comb begin : selLogic
    logic [SEL_W-1:0] sel;
    logic             selRdy;
    logic             found;
    fwd_sel   = '0;
    anyHazard = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      sel    = '0;
      selRdy = 1'b1;
      found  = 1'b0;
      for (int unsigned k = 0; k < NUM_STG; k++) begin
        if (!found && src_valid[i] && stg_wr[k] &&
            (stg_addr[k*ADDR_W +: ADDR_W] != '0) &&
            (stg_addr[k*ADDR_W +: ADDR_W] == src_addr[i*ADDR_W +: ADDR_W])) begin
          found  = 1'b1;
          sel    = SEL_W'(k + 1);
          selRdy = stg_rdy[k];
        end
      end
      fwd_sel[i*SEL_W +: SEL_W] = sel;
      if (found && !selRdy) anyHazard = 1'b1;
    end
  end

  assign stall  = anyHazard & ~wd_err;
  assign anyFwd = |fwd_sel;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= nextState;
  end

  // Next-state logic: the masked stall drives the FSM, so a tripped watchdog
  // sends it back to RUN.
  always_comb begin
    nextState = state;
    case (state)
      RUN:     if (stall)  nextState = HOLD;
      HOLD:    if (!stall) nextState = RUN;
      default: nextState = RUN;
    endcase
  end

  // FSM control outputs; the watchdog trips on the edge where the run counter
  // would reach MAX_STALL, giving MAX_STALL+1 stall cycles per episode.
  always_comb begin
    enterHold = (state == RUN)  && stall;
    holdTick  = (state == HOLD) && stall;
    wdTrip    = holdTick && (runCnt == 8'(MAX_STALL - 1));
  end

  // Run counter for the current stall episode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         runCnt <= '0;
    else if (enterHold) runCnt <= '0;
    else if (holdTick)  runCnt <= runCnt + 8'd1;
  end

  // Sticky watchdog error, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      wd_err <= 1'b0;
    else if (wdTrip) wd_err <= 1'b1;
  end

  // Saturating stall and forward activity counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (stall && (stall_cnt != '1))            stall_cnt <= stall_cnt + 16'd1;
      if (anyFwd && !stall && (fwd_cnt != '1))   fwd_cnt   <= fwd_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed bench for forward_hazard_unit: a 2x2 instance with a short
// watchdog, and a 1x1 instance used for counter saturation.
module tb_forward_hazard_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: NUM_SRC=2, NUM_STG=2, MAX_STALL=3
  logic        rstA;
  logic [9:0]  srcAddrA;
  logic [1:0]  srcValidA;
  logic [1:0]  stgWrA;
  logic [9:0]  stgAddrA;
  logic [1:0]  stgRdyA;
  logic [3:0]  fwdSelA;
  logic        stallA;
  logic        wdErrA;
  logic [15:0] stallCntA;
  logic [15:0] fwdCntA;

  // Instance B: NUM_SRC=1, NUM_STG=1, MAX_STALL=255
  logic        rstB;
  logic [4:0]  srcAddrB;
  logic        srcValidB;
  logic        stgWrB;
  logic [4:0]  stgAddrB;
  logic        stgRdyB;
  logic        fwdSelB;
  logic        stallB;
  logic        wdErrB;
  logic [15:0] stallCntB;
  logic [15:0] fwdCntB;

  int nChecks = 0;
  int nErrors = 0;

  forward_hazard_unit #(.NUM_SRC(2), .NUM_STG(2), .ADDR_W(5), .MAX_STALL(3)) dutA (
    .clk(clk), .rst_n(rstA), .src_addr(srcAddrA), .src_valid(srcValidA),
    .stg_wr(stgWrA), .stg_addr(stgAddrA), .stg_rdy(stgRdyA),
    .fwd_sel(fwdSelA), .stall(stallA), .wd_err(wdErrA),
    .stall_cnt(stallCntA), .fwd_cnt(fwdCntA)
  );

  forward_hazard_unit #(.NUM_SRC(1), .NUM_STG(1), .ADDR_W(5), .MAX_STALL(255)) dutB (
    .clk(clk), .rst_n(rstB), .src_addr(srcAddrB), .src_valid(srcValidB),
    .stg_wr(stgWrB), .stg_addr(stgAddrB), .stg_rdy(stgRdyB),
    .fwd_sel(fwdSelB), .stall(stallB), .wd_err(wdErrB),
    .stall_cnt(stallCntB), .fwd_cnt(fwdCntB)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // src1, src0, valid, stage wr, stage2 addr, stage1 addr, rdy
  task automatic setA(input logic [4:0] s1, input logic [4:0] s0, input logic [1:0] v,
                      input logic [1:0] wr, input logic [4:0] a2, input logic [4:0] a1,
                      input logic [1:0] rdy);
    srcAddrA  = {s1, s0};
    srcValidA = v;
    stgWrA    = wr;
    stgAddrA  = {a2, a1};
    stgRdyA   = rdy;
  endtask

  int rem;
  int n;

  initial begin
    rstA = 1'b0;
    rstB = 1'b0;
    setA(5'd0, 5'd0, 2'b00, 2'b00, 5'd0, 5'd0, 2'b11);
    srcAddrB = 5'd0; srcValidB = 1'b0; stgWrB = 1'b0; stgAddrB = 5'd0; stgRdyB = 1'b1;

    // Reset values and combinational outputs during reset
    #12;
    chk("rst_stall_cnt", 32'(stallCntA), 32'h0);
    chk("rst_fwd_cnt",   32'(fwdCntA),   32'h0);
    chk("rst_wd_err",    32'(wdErrA),    32'h0);
    chk("rst_fwd_sel",   32'(fwdSelA),   32'h0);
    setA(5'd0, 5'd5, 2'b01, 2'b01, 5'd0, 5'd5, 2'b10);
    #1;
    chk("rst_comb_fwd_sel", 32'(fwdSelA), 32'h1);
    chk("rst_comb_stall",   32'(stallA),  32'h1);
    setA(5'd0, 5'd0, 2'b00, 2'b00, 5'd0, 5'd0, 2'b11);
    #1 rstA = 1'b1;
    step();

    // Nearest ready stage forwards
    setA(5'd0, 5'd5, 2'b01, 2'b11, 5'd5, 5'd5, 2'b11);
    #1;
    chk("fwd_s1_sel",   32'(fwdSelA), 32'h1);
    chk("fwd_s1_stall", 32'(stallA),  32'h0);
    step();
    chk("fwd_cnt_1", 32'(fwdCntA), 32'h1);

    // Operand 1 forwards from stage 2 while operand 0 uses stage 1
    setA(5'd7, 5'd5, 2'b11, 2'b11, 5'd7, 5'd5, 2'b11);
    #1;
    chk("fwd_two_ops_sel", 32'(fwdSelA), 32'h9);
    step();
    chk("fwd_cnt_2", 32'(fwdCntA), 32'h2);

    // Address 0, invalid operand, and no-write never forward or stall
    setA(5'd0, 5'd0, 2'b01, 2'b01, 5'd0, 5'd0, 2'b00);
    #1;
    chk("addr0_sel",   32'(fwdSelA), 32'h0);
    chk("addr0_stall", 32'(stallA),  32'h0);
    setA(5'd0, 5'd3, 2'b00, 2'b01, 5'd0, 5'd3, 2'b00);
    #1;
    chk("invalid_sel",   32'(fwdSelA), 32'h0);
    chk("invalid_stall", 32'(stallA),  32'h0);
    setA(5'd0, 5'd3, 2'b01, 2'b00, 5'd0, 5'd3, 2'b00);
    #1;
    chk("nowr_sel", 32'(fwdSelA), 32'h0);
    step();
    chk("fwd_cnt_unchanged", 32'(fwdCntA), 32'h2);

    // Nearer stage not ready: stall, no stale forward; operand 1 still forwards
    setA(5'd7, 5'd5, 2'b11, 2'b11, 5'd7, 5'd5, 2'b10);
    #1;
    chk("haz_mixed_sel",   32'(fwdSelA), 32'h9);
    chk("haz_mixed_stall", 32'(stallA),  32'h1);
    step();
    chk("haz_stall_cnt_1", 32'(stallCntA), 32'h1);
    chk("haz_fwd_cnt_hold", 32'(fwdCntA),  32'h2);
    step();
    chk("haz_stall_cnt_2", 32'(stallCntA), 32'h2);
    stgRdyA = 2'b11;
    #1;
    chk("haz_clear_stall", 32'(stallA), 32'h0);
    step();
    chk("haz_clear_fwd_cnt", 32'(fwdCntA),   32'h3);
    chk("haz_clear_stl_cnt", 32'(stallCntA), 32'h2);

    // Watchdog with MAX_STALL=3: four stall cycles, then stall forced low
    setA(5'd0, 5'd0, 2'b00, 2'b00, 5'd0, 5'd0, 2'b11);
    step();
    setA(5'd0, 5'd5, 2'b01, 2'b01, 5'd0, 5'd5, 2'b10);
    #1;
    chk("wd_stall_c1", 32'(stallA), 32'h1);
    step();
    step();
    step();
    chk("wd_stall_c4", 32'(stallA), 32'h1);
    chk("wd_err_c4",   32'(wdErrA), 32'h0);
    step();
    chk("wd_err_set",      32'(wdErrA),    32'h1);
    chk("wd_stall_forced", 32'(stallA),    32'h0);
    chk("wd_stall_cnt",    32'(stallCntA), 32'h6);
    step();
    step();
    chk("wd_err_sticky",     32'(wdErrA),    32'h1);
    chk("wd_stall_cnt_hold", 32'(stallCntA), 32'h6);
    chk("wd_fwd_cnt",        32'(fwdCntA),   32'h5);
    #2 rstA = 1'b0;
    #1;
    chk("wd_rst_err",   32'(wdErrA), 32'h0);
    chk("wd_rst_stall", 32'(stallA), 32'h1);
    chk("wd_rst_fwd",   32'(fwdCntA), 32'h0);
    setA(5'd0, 5'd0, 2'b00, 2'b00, 5'd0, 5'd0, 2'b11);
    #1 rstA = 1'b1;
    step();

    // Build stall_cnt=7 in HOLD, then reset asynchronously mid-episode
    for (int e = 0; e < 2; e++) begin
      setA(5'd0, 5'd5, 2'b01, 2'b01, 5'd0, 5'd5, 2'b10);
      step();
      step();
      step();
      setA(5'd0, 5'd0, 2'b00, 2'b00, 5'd0, 5'd0, 2'b11);
      step();
    end
    chk("ep_wd_clear", 32'(wdErrA), 32'h0);
    setA(5'd0, 5'd5, 2'b01, 2'b01, 5'd0, 5'd5, 2'b10);
    step();
    chk("ep_stall_cnt_7", 32'(stallCntA), 32'h7);
    #2 rstA = 1'b0;
    #1;
    chk("mid_rst_stall_cnt", 32'(stallCntA), 32'h0);
    chk("mid_rst_wd_err",    32'(wdErrA),    32'h0);
    setA(5'd0, 5'd0, 2'b00, 2'b00, 5'd0, 5'd0, 2'b11);
    #1 rstA = 1'b1;
    step();
    // A fresh episode from RUN again takes four stall cycles to trip
    setA(5'd0, 5'd5, 2'b01, 2'b01, 5'd0, 5'd5, 2'b10);
    step();
    step();
    step();
    chk("post_rst_stall", 32'(stallA), 32'h1);
    chk("post_rst_wd0",   32'(wdErrA), 32'h0);
    step();
    chk("post_rst_wd1",   32'(wdErrA), 32'h1);

    // Instance B: 1x1 configuration and stall_cnt saturation
    #1 rstB = 1'b1;
    step();
    srcAddrB = 5'd5; srcValidB = 1'b1; stgWrB = 1'b1; stgAddrB = 5'd5; stgRdyB = 1'b0;
    #1;
    chk("b_fwd_sel", 32'(fwdSelB), 32'h1);
    chk("b_stall",   32'(stallB),  32'h1);
    rem = 65535;
    while (rem > 0) begin
      n = (rem > 200) ? 200 : rem;
      srcValidB = 1'b1;
      repeat (n) step();
      rem -= n;
      srcValidB = 1'b0;
      step();
    end
    chk("b_stall_cnt_max", 32'(stallCntB), 32'hFFFF);
    chk("b_wd_clear",      32'(wdErrB),    32'h0);
    chk("b_fwd_cnt",       32'(fwdCntB),   32'h0);
    srcValidB = 1'b1;
    #1;
    chk("b_extra_stall", 32'(stallB), 32'h1);
    step();
    chk("b_stall_cnt_sat", 32'(stallCntB), 32'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
